// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, drives the instruction-memory address, and applies the hazard
// unit's stall and redirect controls. It also keeps saturating event counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_if,
   input  logic        stall_id,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count,
   output logic [31:0] imem_wait_count,
   output logic [31:0] fetch_count
);

   logic [31:0] pc;
   logic [31:0] pc_next_seq;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
   logic [31:0] wait_cnt;
   logic [31:0] fetch_cnt;

   // Event counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

   assign pc_next_seq     = pc + 32'd4;
   assign imem_addr       = pc;
   assign stall_count     = stall_cnt;
   assign flush_count     = flush_cnt;
   assign imem_wait_count = wait_cnt;
   assign fetch_count     = fetch_cnt;

   // PC, IF/ID and counter update: redirect beats stall, stall beats memory
   // wait, and a plain fetch happens only when nothing else applies. A
   // stall always holds the PC, even a stall_id-only one, so the word fetched
   // that cycle is re-presented rather than lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc             <= RESET_PC;
         if_id_pc       <= 32'h0000_0000;
         if_id_pc_plus4 <= 32'h0000_0000;
         if_id_instr    <= NOP_INSTR;
         if_id_valid    <= 1'b0;
         stall_cnt      <= 32'h0000_0000;
         flush_cnt      <= 32'h0000_0000;
         wait_cnt       <= 32'h0000_0000;
         fetch_cnt      <= 32'h0000_0000;
      end else if (branch_taken) begin
         pc          <= {branch_target[31:2], 2'b00};
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
         flush_cnt   <= sat_inc(flush_cnt);
      end else if (stall_if || stall_id) begin
         if (!stall_id) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
         end
         stall_cnt <= sat_inc(stall_cnt);
      end else if (!imem_ready) begin
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
         wait_cnt    <= sat_inc(wait_cnt);
      end else begin
         pc             <= pc_next_seq;
         if_id_pc       <= pc;
         if_id_pc_plus4 <= pc_next_seq;
         if_id_instr    <= imem_rdata;
         if_id_valid    <= 1'b1;
         fetch_cnt      <= sat_inc(fetch_cnt);
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks for fetch_unit with RESET_PC = 0x100.
// Instruction memory returns {16'hC0DE, addr[15:0]}, so every expected word
// below is written out by hand from its address.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_if = 1'b0;
   logic        stall_id = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready = 1'b1;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic [31:0] stall_count;
   logic [31:0] flush_count;
   logic [31:0] imem_wait_count;
   logic [31:0] fetch_count;

   int n_cmp = 0;
   int n_fail = 0;

   fetch_unit #(.RESET_PC(32'h0000_0100), .NOP_INSTR(32'h0000_0013)) dut (
      .clk(clk), .rst_n(rst_n), .stall_if(stall_if), .stall_id(stall_id),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
      .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
      .stall_count(stall_count), .flush_count(flush_count),
      .imem_wait_count(imem_wait_count), .fetch_count(fetch_count)
   );

   assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step();
      if (imem_addr !== 32'h100) begin $display("FAIL rst_addr: got %h want %h", imem_addr, 32'h100); n_fail++; end n_cmp++;
      if (if_id_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", if_id_valid); n_fail++; end n_cmp++;
      if (if_id_instr !== 32'h13) begin $display("FAIL rst_instr: got %h want 13", if_id_instr); n_fail++; end n_cmp++;
      if ({if_id_pc, if_id_pc_plus4} !== 64'h0) begin $display("FAIL rst_pcs: got %h/%h want 0/0", if_id_pc, if_id_pc_plus4); n_fail++; end n_cmp++;
      if ({stall_count, flush_count, imem_wait_count, fetch_count} !== 128'h0) begin $display("FAIL rst_counters: got %h %h %h %h want 0", stall_count, flush_count, imem_wait_count, fetch_count); n_fail++; end n_cmp++;
      rst_n = 1'b1;
   endtask

   task automatic test_seq_fetch();
      logic [31:0] exp_pc;
      for (int i = 0; i < 4; i++) begin
         step();
         exp_pc = 32'h100 + 32'(4 * i);
         if (if_id_pc !== exp_pc) begin $display("FAIL seq_pc[%0d]: got %h want %h", i, if_id_pc, exp_pc); n_fail++; end n_cmp++;
         if (if_id_pc_plus4 !== exp_pc + 32'd4) begin $display("FAIL seq_pc4[%0d]: got %h want %h", i, if_id_pc_plus4, exp_pc + 32'd4); n_fail++; end n_cmp++;
         if (if_id_instr !== {16'hC0DE, exp_pc[15:0]}) begin $display("FAIL seq_instr[%0d]: got %h want %h", i, if_id_instr, {16'hC0DE, exp_pc[15:0]}); n_fail++; end n_cmp++;
         if (if_id_valid !== 1'b1) begin $display("FAIL seq_valid[%0d]: got %b want 1", i, if_id_valid); n_fail++; end n_cmp++;
      end
      if (fetch_count !== 32'd4) begin $display("FAIL seq_fetch_count: got %0d want 4", fetch_count); n_fail++; end n_cmp++;
      if (imem_addr !== 32'h110) begin $display("FAIL seq_addr: got %h want 110", imem_addr); n_fail++; end n_cmp++;
   endtask

   task automatic test_load_use_stall();
      stall_if = 1'b1; stall_id = 1'b1;
      step();
      stall_if = 1'b0; stall_id = 1'b0;
      if (imem_addr !== 32'h110) begin $display("FAIL lu_addr: got %h want 110", imem_addr); n_fail++; end n_cmp++;
      if (if_id_pc !== 32'h10C || if_id_valid !== 1'b1 || if_id_instr !== 32'hC0DE010C) begin $display("FAIL lu_ifid: got %h/%b/%h want 10c/1/c0de010c", if_id_pc, if_id_valid, if_id_instr); n_fail++; end n_cmp++;
      if (stall_count !== 32'd1 || fetch_count !== 32'd4) begin $display("FAIL lu_counts: got stall %0d fetch %0d want 1 4", stall_count, fetch_count); n_fail++; end n_cmp++;
      step();
      if (if_id_pc !== 32'h110 || if_id_instr !== 32'hC0DE0110 || if_id_valid !== 1'b1) begin $display("FAIL lu_resume: got %h/%h/%b want 110/c0de0110/1", if_id_pc, if_id_instr, if_id_valid); n_fail++; end n_cmp++;
      if (imem_addr !== 32'h114 || fetch_count !== 32'd5) begin $display("FAIL lu_resume_addr: got %h fetch %0d want 114 5", imem_addr, fetch_count); n_fail++; end n_cmp++;
   endtask

   task automatic test_redirect_in_stall();
      branch_taken = 1'b1; branch_target = 32'h203; stall_if = 1'b1; stall_id = 1'b1;
      step();
      branch_taken = 1'b0; stall_if = 1'b0; stall_id = 1'b0;
      if (imem_addr !== 32'h200) begin $display("FAIL rd_addr: got %h want 200", imem_addr); n_fail++; end n_cmp++;
      if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin $display("FAIL rd_bubble: got %b/%h want 0/13", if_id_valid, if_id_instr); n_fail++; end n_cmp++;
      if (if_id_pc !== 32'h110 || if_id_pc_plus4 !== 32'h114) begin $display("FAIL rd_pc_hold: got %h/%h want 110/114", if_id_pc, if_id_pc_plus4); n_fail++; end n_cmp++;
      if (flush_count !== 32'd1 || stall_count !== 32'd1) begin $display("FAIL rd_counts: got flush %0d stall %0d want 1 1", flush_count, stall_count); n_fail++; end n_cmp++;
   endtask

   task automatic test_imem_wait();
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (imem_addr !== 32'h200 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin $display("FAIL wait[%0d]: got %h/%b/%h want 200/0/13", i, imem_addr, if_id_valid, if_id_instr); n_fail++; end n_cmp++;
      end
      if (imem_wait_count !== 32'd3) begin $display("FAIL wait_count: got %0d want 3", imem_wait_count); n_fail++; end n_cmp++;
      imem_ready = 1'b1;
      step();
      if (if_id_pc !== 32'h200 || if_id_valid !== 1'b1 || if_id_instr !== 32'hC0DE0200) begin $display("FAIL wait_ready: got %h/%b/%h want 200/1/c0de0200", if_id_pc, if_id_valid, if_id_instr); n_fail++; end n_cmp++;
      if (imem_addr !== 32'h204 || fetch_count !== 32'd6) begin $display("FAIL wait_after: got %h fetch %0d want 204 6", imem_addr, fetch_count); n_fail++; end n_cmp++;
   endtask

   task automatic test_partial_stalls();
      stall_id = 1'b1;
      step();
      stall_id = 1'b0;
      if (imem_addr !== 32'h204 || if_id_pc !== 32'h200 || if_id_valid !== 1'b1) begin $display("FAIL sid_hold: got %h/%h/%b want 204/200/1", imem_addr, if_id_pc, if_id_valid); n_fail++; end n_cmp++;
      if (stall_count !== 32'd2 || fetch_count !== 32'd6) begin $display("FAIL sid_counts: got stall %0d fetch %0d want 2 6", stall_count, fetch_count); n_fail++; end n_cmp++;
      stall_if = 1'b1;
      step();
      stall_if = 1'b0;
      if (imem_addr !== 32'h204 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13 || if_id_pc !== 32'h200) begin $display("FAIL sif_bubble: got %h/%b/%h/%h want 204/0/13/200", imem_addr, if_id_valid, if_id_instr, if_id_pc); n_fail++; end n_cmp++;
      if (stall_count !== 32'd3) begin $display("FAIL sif_count: got %0d want 3", stall_count); n_fail++; end n_cmp++;
      step();
      if (if_id_pc !== 32'h204 || if_id_valid !== 1'b1 || imem_addr !== 32'h208 || fetch_count !== 32'd7) begin $display("FAIL sif_resume: got %h/%b/%h/%0d want 204/1/208/7", if_id_pc, if_id_valid, imem_addr, fetch_count); n_fail++; end n_cmp++;
   endtask

   task automatic test_wrap_and_saturation();
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE; imem_ready = 1'b0;
      step();
      branch_taken = 1'b0; imem_ready = 1'b1;
      if (imem_addr !== 32'hFFFF_FFFC) begin $display("FAIL wrap_target: got %h want fffffffc", imem_addr); n_fail++; end n_cmp++;
      if (flush_count !== 32'd2 || imem_wait_count !== 32'd3) begin $display("FAIL wrap_counts: got flush %0d wait %0d want 2 3", flush_count, imem_wait_count); n_fail++; end n_cmp++;
      step();
      if (imem_addr !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'h0) begin $display("FAIL wrap_fetch: got %h/%h/%h want 0/fffffffc/0", imem_addr, if_id_pc, if_id_pc_plus4); n_fail++; end n_cmp++;
      if (if_id_instr !== 32'hC0DE_FFFC || fetch_count !== 32'd8) begin $display("FAIL wrap_instr: got %h fetch %0d want c0defffc 8", if_id_instr, fetch_count); n_fail++; end n_cmp++;
      force dut.fetch_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_cnt;
      step();
      if (fetch_count !== 32'hFFFF_FFFF) begin $display("FAIL sat_fetch: got %h want ffffffff", fetch_count); n_fail++; end n_cmp++;
      if (if_id_pc !== 32'h0 || imem_addr !== 32'h4) begin $display("FAIL sat_pc: got %h/%h want 0/4", if_id_pc, imem_addr); n_fail++; end n_cmp++;
   endtask

   task automatic test_async_reset();
      stall_if = 1'b1;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      if (imem_addr !== 32'h100 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13 || if_id_pc !== 32'h0) begin $display("FAIL areset_state: got %h/%b/%h/%h want 100/0/13/0", imem_addr, if_id_valid, if_id_instr, if_id_pc); n_fail++; end n_cmp++;
      if ({stall_count, flush_count, imem_wait_count, fetch_count} !== 128'h0) begin $display("FAIL areset_counters: got %h %h %h %h want 0", stall_count, flush_count, imem_wait_count, fetch_count); n_fail++; end n_cmp++;
      stall_if = 1'b0;
      rst_n = 1'b1;
      step();
      if (if_id_pc !== 32'h100 || if_id_valid !== 1'b1 || imem_addr !== 32'h104 || fetch_count !== 32'd1) begin $display("FAIL areset_restart: got %h/%b/%h/%0d want 100/1/104/1", if_id_pc, if_id_valid, imem_addr, fetch_count); n_fail++; end n_cmp++;
   endtask

   initial begin
      test_reset();
      test_seq_fetch();
      test_load_use_stall();
      test_redirect_in_stall();
      test_imem_wait();
      test_partial_stalls();
      test_wrap_and_saturation();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
